// File: rtl/c17_lane_pipe_pkg.sv
// Lane field widths, bit indices and the C17 split-point functions shared by the lane pipeline.
package c17_pkg;

    localparam int IN_W  = 5;
    localparam int OUT_W = 2;
    localparam int MID_W = 3;

    localparam int G1_IDX  = 0;
    localparam int G2_IDX  = 1;
    localparam int G3_IDX  = 2;
    localparam int G6_IDX  = 3;
    localparam int G7_IDX  = 4;

    localparam int O22_IDX = 0;
    localparam int O23_IDX = 1;

    // Stage-1 cut of the network, packed MSB-first as {n8,n10,n12}.
    typedef struct packed {
        logic n8;
        logic n10;
        logic n12;
    } c17_mid_t;

    function automatic logic [MID_W-1:0] c17_mid(input logic [IN_W-1:0] g);
        c17_mid_t m;
        logic     n9;
        n9    = g[G3_IDX] & g[G6_IDX];
        m.n8  = g[G1_IDX] & g[G3_IDX];
        m.n10 = g[G2_IDX] & ~n9;
        m.n12 = g[G7_IDX] & ~n9;
        return m;
    endfunction

    function automatic logic [OUT_W-1:0] c17_fin(input logic [MID_W-1:0] mid);
        c17_mid_t         m;
        logic [OUT_W-1:0] o;
        m          = mid;
        o[O22_IDX] = m.n8 | m.n10;
        o[O23_IDX] = m.n10 | m.n12;
        return o;
    endfunction

    function automatic logic [OUT_W-1:0] c17_eval(input logic [IN_W-1:0] g);
        return c17_fin(c17_mid(g));
    endfunction

endpackage

// File: rtl/c17_lane_pipe_stage_reg.sv
// One valid/ready pipeline slice; the data register only loads on an accepted transfer.
module c17_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         load_s;

    // Slice can take a new item when empty or when its current item leaves this cycle.
    always_comb begin
        load_s  = ~valid_q | out_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (load_s) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = load_s;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/c17_lane_pipe.sv
// Multi-lane pipelined C17 evaluator with valid/ready flow control.
// Optional output toggle counter enabled by defining C17_TOGGLE_CNT_EN.
module c17_lane_pipe
    import c17_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W*LANES-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W*LANES-1:0] out_data
`ifdef C17_TOGGLE_CNT_EN
    ,
    input  logic                   tgl_clr,
    output logic [CNT_W-1:0]       tgl_count
`endif
);

    localparam int MW = MID_W * LANES;
    localparam int OW = OUT_W * LANES;

    if ((LANES < 1) || (CNT_W < 1) || (STAGES < 1) || (STAGES > 2)) begin : g_bad_cfg
        $error("c17_lane_pipe: unsupported parameter combination");
    end

`ifdef C17_TOGGLE_CNT_EN
    logic          last_load_s;
    logic [OW-1:0] last_new_s;
`endif

    if (STAGES == 1) begin : g_one
        logic [OW-1:0] eval_s;

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign eval_s[l*OUT_W +: OUT_W] = c17_eval(in_data[l*IN_W +: IN_W]);
        end

        c17_stage_reg #(.W(OW)) u_out (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (eval_s),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
        );

`ifdef C17_TOGGLE_CNT_EN
        assign last_load_s = in_valid & in_ready;
        assign last_new_s  = eval_s;
`endif
    end else begin : g_two
        logic [MW-1:0] mid_s;
        logic [MW-1:0] mid_q_s;
        logic [OW-1:0] fin_s;
        logic          s1_valid_s;
        logic          s2_ready_s;

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign mid_s[l*MID_W +: MID_W] = c17_mid(in_data[l*IN_W +: IN_W]);
            assign fin_s[l*OUT_W +: OUT_W] = c17_fin(mid_q_s[l*MID_W +: MID_W]);
        end

        c17_stage_reg #(.W(MW)) u_s1 (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (mid_s),
            .out_valid (s1_valid_s),
            .out_ready (s2_ready_s),
            .out_data  (mid_q_s)
        );

        c17_stage_reg #(.W(OW)) u_s2 (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (s1_valid_s),
            .in_ready  (s2_ready_s),
            .in_data   (fin_s),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data)
        );

`ifdef C17_TOGGLE_CNT_EN
        assign last_load_s = s1_valid_s & s2_ready_s;
        assign last_new_s  = fin_s;
`endif
    end

`ifdef C17_TOGGLE_CNT_EN
    localparam int PC_W  = $clog2(OW + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [CNT_W-1:0] tgl_q;
    logic [CNT_W-1:0] tgl_d;
    logic [OW-1:0]    chg_s;
    logic [PC_W-1:0]  pc_s;
    logic [SUM_W-1:0] sum_s;

    // Output register currently holds the old value, so the XOR is the bits about to flip.
    always_comb begin
        chg_s = out_data ^ last_new_s;
        pc_s  = {PC_W{1'b0}};
        for (int b = 0; b < OW; b++) begin
            pc_s = pc_s + PC_W'(chg_s[b]);
        end
        sum_s = SUM_W'(tgl_q) + SUM_W'(pc_s);
        tgl_d = tgl_q;
        if (tgl_clr) begin
            tgl_d = {CNT_W{1'b0}};
        end else if (last_load_s) begin
            if (sum_s > SUM_W'({CNT_W{1'b1}})) begin
                tgl_d = {CNT_W{1'b1}};
            end else begin
                tgl_d = sum_s[CNT_W-1:0];
            end
        end else begin
            tgl_d = tgl_q;
        end
    end

    // Toggle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgl_q <= {CNT_W{1'b0}};
        end else begin
            tgl_q <= tgl_d;
        end
    end

    assign tgl_count = tgl_q;
`endif

endmodule

// File: tb/tb_c17_lane_pipe.sv
// Self-checking bench: a STAGES=2 and a STAGES=1 instance share stimulus, each tracked by a
// transfer-level queue model. Counter checks are compiled in with C17_TOGGLE_CNT_EN.
module tb_c17_lane_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [19:0] in_data;
    logic        out_ready;
    logic        ir [2];
    logic        ov [2];
    logic [7:0]  od [2];
`ifdef C17_TOGGLE_CNT_EN
    logic        tgl_clr;
    logic [15:0] tc0;
    logic [3:0]  tc1;
`endif

    int errors = 0;
    int checks = 0;

    c17_lane_pipe #(.LANES(4), .STAGES(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0])
`ifdef C17_TOGGLE_CNT_EN
        , .tgl_clr(tgl_clr), .tgl_count(tc0)
`endif
    );

    c17_lane_pipe #(.LANES(4), .STAGES(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1])
`ifdef C17_TOGGLE_CNT_EN
        , .tgl_clr(tgl_clr), .tgl_count(tc1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Classic NAND-gate form of C17, evaluated for all four lanes.
    function automatic logic [7:0] ref_eval(input logic [19:0] v);
        logic [7:0] r;
        logic [4:0] g;
        logic n10, n11, n16, n19;
        for (int l = 0; l < 4; l++) begin
            g   = v[l*5 +: 5];
            n10 = ~(g[0] & g[2]);
            n11 = ~(g[2] & g[3]);
            n16 = ~(g[1] & n11);
            n19 = ~(n11 & g[4]);
            r[l*2]     = ~(n10 & n16);
            r[l*2 + 1] = ~(n16 & n19);
        end
        return r;
    endfunction

    logic [7:0]  dq [2][$];
    int          eq [2][$];
    int          push_cnt [2];
    int          pop_cnt [2];
    bit          mon_en = 1'b0;
    int          edge_n = 0;
    bit          p_rst = 1'b0;
    bit          p_push [2];
    bit          p_pop [2];
    logic [19:0] p_data;

    // Scoreboard: apply transfers seen before the last edge, then compare every output.
    always @(negedge clk) begin
        if (mon_en) begin
            edge_n++;
            for (int d = 0; d < 2; d++) begin
                int  stg;
                bit  exp_ov;
                bit  exp_ir;
                stg = (d == 0) ? 2 : 1;
                if (p_rst) begin
                    dq[d].delete();
                    eq[d].delete();
                end else begin
                    if (p_pop[d]) begin
                        void'(dq[d].pop_front());
                        void'(eq[d].pop_front());
                        pop_cnt[d]++;
                    end
                    if (p_push[d]) begin
                        dq[d].push_back(ref_eval(p_data));
                        eq[d].push_back(edge_n);
                        push_cnt[d]++;
                    end
                end
                exp_ov = (dq[d].size() > 0) && ((edge_n - eq[d][0]) >= (stg - 1));
                exp_ir = (dq[d].size() < stg) || out_ready;
                check($sformatf("in_ready[s%0d]", stg), 32'(ir[d]), 32'(exp_ir));
                check($sformatf("out_valid[s%0d]", stg), 32'(ov[d]), 32'(exp_ov));
                if (exp_ov) begin
                    check($sformatf("out_data[s%0d]", stg), 32'(od[d]), 32'(dq[d][0]));
                end
                p_push[d] = in_valid && exp_ir && !rst;
                p_pop[d]  = exp_ov && out_ready && !rst;
            end
            p_rst  = rst;
            p_data = in_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifdef C17_TOGGLE_CNT_EN
    task automatic send(input logic [19:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        repeat (2) step();
    endtask
`endif

    int base_pop [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            push_cnt[d] = 0;
            pop_cnt[d]  = 0;
            p_push[d]   = 1'b0;
            p_pop[d]    = 1'b0;
        end
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 20'($urandom);
        out_ready = 1'b1;
`ifdef C17_TOGGLE_CNT_EN
        tgl_clr   = 1'b0;
`endif
        step();
        mon_en = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_out_data", 32'(od[0]), 32'd0);
        check("rst_in_ready", 32'(ir[0]), 32'd1);
        check("rst_out_data_s1", 32'(od[1]), 32'd0);
`ifdef C17_TOGGLE_CNT_EN
        check("rst_tgl_count", 32'(tc0), 32'd0);
`endif
        step();

        // Directed lane vectors: lane3..lane0 = 11100,10010,11111,00101.
        in_valid = 1'b1;
        in_data  = 20'b11100_10010_11111_00101;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("dir_s2_not_yet", 32'(ov[0]), 32'd0);
        check("dir_s1_valid", 32'(ov[1]), 32'd1);
        check("dir_s1_data", 32'(od[1]), 32'h35);
        @(negedge clk);
        check("dir_s2_valid", 32'(ov[0]), 32'd1);
        check("dir_s2_data", 32'(od[0]), 32'h35);
        repeat (2) step();

        // Back-to-back random stream with the sink always ready.
        base_pop[0] = pop_cnt[0];
        base_pop[1] = pop_cnt[1];
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 20'($urandom);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        check("stream_cnt_s2", 32'(pop_cnt[0] - base_pop[0]), 32'd100);
        check("stream_cnt_s1", 32'(pop_cnt[1] - base_pop[1]), 32'd100);

        // Backpressure: sink stalls for 5 cycles while the source keeps offering.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 20'($urandom);
            step();
        end
        @(negedge clk);
        check("bp_in_ready_s2", 32'(ir[0]), 32'd0);
        check("bp_in_ready_s1", 32'(ir[1]), 32'd0);
        check("bp_held_s2", 32'(dq[0].size()), 32'd2);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("bp_balance_s2", 32'(pop_cnt[0]), 32'(push_cnt[0]));
        check("bp_balance_s1", 32'(pop_cnt[1]), 32'(push_cnt[1]));

        // Random valid/ready mix.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 20'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("mix_balance_s2", 32'(pop_cnt[0]), 32'(push_cnt[0]));
        check("mix_balance_s1", 32'(pop_cnt[1]), 32'(push_cnt[1]));

        // Reset with a partly filled pipe discards everything.
        in_valid = 1'b1;
        in_data  = 20'($urandom);
        step();
        rst = 1'b1;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_valid_s2", 32'(ov[0]), 32'd0);
        check("midrst_data_s2", 32'(od[0]), 32'd0);
        step();

`ifdef C17_TOGGLE_CNT_EN
        send({4{5'b10010}});
        check("tgl_ff_s2", 32'(tc0), 32'd8);
        check("tgl_ff_s1", 32'(tc1), 32'd8);
        send(20'd0);
        check("tgl_00_s2", 32'(tc0), 32'd16);
        check("tgl_00_s1_sat", 32'(tc1), 32'd15);
        send(20'd0);
        check("tgl_rep_s2", 32'(tc0), 32'd16);
        tgl_clr  = 1'b1;
        in_valid = 1'b1;
        in_data  = {4{5'b10010}};
        step();
        in_valid = 1'b0;
        step();
        tgl_clr = 1'b0;
        step();
        check("tgl_clr_s2", 32'(tc0), 32'd0);
        check("tgl_clr_s1", 32'(tc1), 32'd0);
        send(20'd0);
        send({4{5'b10010}});
        check("tgl_sat_s1", 32'(tc1), 32'd15);
        send(20'd0);
        send({4{5'b10010}});
        check("tgl_sat_hold_s1", 32'(tc1), 32'd15);
        check("tgl_sum_s2", 32'(tc0), 32'd32);
`endif

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
